// File: rtl/alarm_pkg.sv
// Shared types and mode constants for the alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  localparam logic [2:0] MODE_RUN       = 3'd0;
  localparam logic [2:0] MODE_SET_H     = 3'd1;
  localparam logic [2:0] MODE_SET_M     = 3'd2;
  localparam logic [2:0] MODE_SET_S     = 3'd3;
  localparam logic [2:0] MODE_STOPWATCH = 3'd4;
  localparam logic [2:0] MODE_ALM_M     = 3'd5;
  localparam logic [2:0] MODE_ALM_H     = 3'd6;

  // True while the user is editing the running time.
  function automatic logic is_setting(input logic [2:0] mode);
    return (mode == MODE_SET_H) || (mode == MODE_SET_M) || (mode == MODE_SET_S);
  endfunction

endpackage

// File: rtl/alarm_ctrl_edge.sv
// One-cycle pulse on the rising edge of a level input sampled on clk1hz.
module edge_rise (
  input  logic clk1hz,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk1hz or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm buzzer FSM (idle/ring/snooze) with stop/snooze buttons and an hourly chime.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_LEN   = 60,
  parameter int unsigned SNOOZE_LEN = 300,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned CHIME_LEN  = 3
) (
  input  logic       clk1hz,
  input  logic       rst_n,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] ahour,
  input  logic [7:0] amin,
  input  logic [2:0] state,
  input  logic       alarm_on,
  input  logic       stop,
  input  logic       snooze,
  output logic       ringing,
  output logic       buzzer,
  output logic       snoozing,
  output logic [1:0] snooze_cnt,
  output logic       chime
);

  localparam int unsigned TMax = (RING_LEN > SNOOZE_LEN) ? RING_LEN : SNOOZE_LEN;
  localparam int unsigned TW   = $clog2(TMax);

  localparam logic [TW-1:0] RingLast   = TW'(RING_LEN - 1);
  localparam logic [TW-1:0] SnoozeLast = TW'(SNOOZE_LEN - 1);
  localparam logic [1:0]    SnoozeMax  = 2'(MAX_SNOOZE);
  localparam logic [7:0]    ChimeSecs  = 8'(CHIME_LEN);

  alarm_state_e  fsm_q, fsm_d;
  logic [TW-1:0] ring_tmr_q, ring_tmr_d;
  logic [TW-1:0] snz_tmr_q, snz_tmr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          buzzer_q, buzzer_d;
  logic          ringing_q, snoozing_q, chime_q, chime_d;
  logic          stop_p, snooze_p, match, quit;

  edge_rise u_stop_edge (
    .clk1hz (clk1hz),
    .rst_n  (rst_n),
    .d      (stop),
    .pulse  (stop_p)
  );

  edge_rise u_snooze_edge (
    .clk1hz (clk1hz),
    .rst_n  (rst_n),
    .d      (snooze),
    .pulse  (snooze_p)
  );

  assign match = alarm_on && (hour == ahour) && (min == amin) && (sec == 8'd0) &&
                 !is_setting(state);
  assign quit  = !alarm_on || stop_p;

  always_comb begin
    fsm_d      = fsm_q;
    ring_tmr_d = ring_tmr_q;
    snz_tmr_d  = snz_tmr_q;
    cnt_d      = cnt_q;
    buzzer_d   = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (match) begin
          fsm_d      = RING;
          ring_tmr_d = '0;
          buzzer_d   = 1'b1;
        end
      end
      RING: begin
        if (quit) begin
          fsm_d = IDLE;
          cnt_d = 2'd0;
        end else if (snooze_p && (cnt_q < SnoozeMax)) begin
          fsm_d     = SNOOZE;
          cnt_d     = cnt_q + 2'd1;
          snz_tmr_d = '0;
        end else if (ring_tmr_q == RingLast) begin
          fsm_d = IDLE;
          cnt_d = 2'd0;
        end else begin
          ring_tmr_d = ring_tmr_q + TW'(1);
          buzzer_d   = ~buzzer_q;
        end
      end
      SNOOZE: begin
        if (quit) begin
          fsm_d = IDLE;
          cnt_d = 2'd0;
        end else if (snz_tmr_q == SnoozeLast) begin
          fsm_d      = RING;
          ring_tmr_d = '0;
          buzzer_d   = 1'b1;
        end else begin
          snz_tmr_d = snz_tmr_q + TW'(1);
        end
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = 2'd0;
      end
    endcase
    // The chime yields to the buzzer whenever the alarm is about to ring.
    chime_d = (min == 8'd0) && (sec < ChimeSecs) && !is_setting(state) && (fsm_d != RING);
  end

  always_ff @(posedge clk1hz or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= IDLE;
      ring_tmr_q <= '0;
      snz_tmr_q  <= '0;
      cnt_q      <= 2'd0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      chime_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      ring_tmr_q <= ring_tmr_d;
      snz_tmr_q  <= snz_tmr_d;
      cnt_q      <= cnt_d;
      buzzer_q   <= buzzer_d;
      ringing_q  <= (fsm_d == RING);
      snoozing_q <= (fsm_d == SNOOZE);
      chime_q    <= chime_d;
    end
  end

  assign ringing    = ringing_q;
  assign buzzer     = buzzer_q;
  assign snoozing   = snoozing_q;
  assign snooze_cnt = cnt_q;
  assign chime      = chime_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus randomized stimulus vs a model.
module tb_alarm_ctrl;

  localparam int RL = 60;
  localparam int SL = 300;
  localparam int MS = 3;
  localparam int CL = 3;

  logic       clk1hz = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] hour, min, sec, ahour, amin;
  logic [2:0] state;
  logic       alarm_on, stop, snooze;
  logic       ringing, buzzer, snoozing, chime;
  logic [1:0] snooze_cnt;

  alarm_ctrl dut (
    .clk1hz     (clk1hz),
    .rst_n      (rst_n),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .ahour      (ahour),
    .amin       (amin),
    .state      (state),
    .alarm_on   (alarm_on),
    .stop       (stop),
    .snooze     (snooze),
    .ringing    (ringing),
    .buzzer     (buzzer),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .chime      (chime)
  );

  always #5 clk1hz = ~clk1hz;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 quiet, 1 ringing, 2 snoozing; elapsed-time counters.
  int ph, ring_el, snz_el, nsnz;
  bit pstop, psnz, m_chime;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; ring_el = 0; snz_el = 0; nsnz = 0;
    pstop = 1'b0; psnz = 1'b0; m_chime = 1'b0;
  endtask

  task automatic model_edge();
    bit sp, zp, setting, hit;
    sp = stop && !pstop;
    zp = snooze && !psnz;
    pstop = stop;
    psnz  = snooze;
    setting = (state >= 3'd1) && (state <= 3'd3);
    hit = alarm_on && hour == ahour && min == amin && sec == 8'd0 && !setting;
    case (ph)
      0: if (hit) begin ph = 1; ring_el = 0; nsnz = 0; end
      1: begin
        if (!alarm_on || sp) ph = 0;
        else if (zp && nsnz < MS) begin ph = 2; nsnz++; snz_el = 0; end
        else begin
          ring_el++;
          if (ring_el == RL) ph = 0;
        end
      end
      default: begin
        if (!alarm_on || sp) ph = 0;
        else begin
          snz_el++;
          if (snz_el == SL) begin ph = 1; ring_el = 0; end
        end
      end
    endcase
    m_chime = (min == 8'd0) && (int'(sec) < CL) && !setting && (ph != 1);
  endtask

  task automatic compare();
    check("ringing", 32'(ringing), 32'(ph == 1));
    check("buzzer", 32'(buzzer), 32'(ph == 1 && (ring_el % 2) == 0));
    check("snoozing", 32'(snoozing), 32'(ph == 2));
    check("snooze_cnt", 32'(snooze_cnt), (ph == 0) ? 0 : nsnz);
    check("chime", 32'(chime), 32'(m_chime));
  endtask

  task automatic tick();
    @(posedge clk1hz);
    model_edge();
    #1;
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 8'(h); min = 8'(m); sec = 8'(s);
  endtask

  // Hit the alarm minute for one edge, then move off second zero.
  task automatic trigger();
    set_time(int'(ahour), int'(amin), 0);
    tick();
    sec = 8'd1;
  endtask

  initial begin
    set_time(7, 29, 59);
    ahour = 8'd7; amin = 8'd30; state = 3'd0;
    alarm_on = 1'b1; stop = 1'b0; snooze = 1'b0;
    model_reset();
    #12;
    compare();
    rst_n = 1'b1;

    // Basic ring: 07:29:59 -> 07:30:00, buzzer toggles, auto-stop after RL cycles.
    tick();
    trigger();
    ticks(RL + 5);

    // Snooze four times; the fourth is ignored.
    trigger();
    for (int k = 0; k < 4; k++) begin
      ticks(2);
      snooze = 1'b1; tick();
      snooze = 1'b0; tick();
      ticks(SL + 2);
    end
    ticks(RL);

    // Stop and snooze together: stop wins.
    trigger();
    ticks(3);
    stop = 1'b1; snooze = 1'b1; tick();
    stop = 1'b0; snooze = 1'b0; ticks(3);

    // Held stop gives one pulse; re-match while held keeps ringing.
    trigger();
    ticks(2);
    stop = 1'b1;
    ticks(4);
    set_time(7, 30, 0); tick(); sec = 8'd1;
    ticks(5);
    stop = 1'b0; tick();
    stop = 1'b1; tick();
    stop = 1'b0; tick();

    // Suppressed matches: setting mode, alarm off.
    state = 3'd2; trigger(); ticks(2);
    state = 3'd0; alarm_on = 1'b0; trigger(); ticks(2);
    alarm_on = 1'b1;

    // Alarm dropped during snooze.
    trigger(); ticks(2);
    snooze = 1'b1; tick(); snooze = 1'b0; ticks(3);
    alarm_on = 1'b0; tick(); alarm_on = 1'b1; ticks(2);

    // Hourly chime, then chime with a coinciding alarm.
    for (int s = 0; s < 5; s++) begin set_time(13, 0, s); tick(); end
    ahour = 8'd13; amin = 8'd0;
    for (int s = 0; s < 5; s++) begin set_time(13, 0, s); tick(); end
    stop = 1'b1; tick(); stop = 1'b0; tick();

    // Asynchronous reset mid-ring.
    ahour = 8'd7; amin = 8'd30;
    trigger(); ticks(5);
    #3 rst_n = 1'b0;
    #1 model_reset();
    compare();
    #2 rst_n = 1'b1;
    ticks(5);

    // Randomized stimulus near the alarm time and the top of the hour.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0) set_time(int'(ahour), int'(amin), $urandom_range(0, 3));
      else set_time($urandom_range(0, 23), 0, $urandom_range(0, 4));
      state    = 3'($urandom_range(0, 6));
      alarm_on = ($urandom_range(0, 15) != 0);
      stop     = ($urandom_range(0, 39) == 0);
      snooze   = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
